calc_param: RTL and testbench

//  Parametrised decimal calculator core: keypad command entry, operand A/B,

---
 rtl/calc_pkg.sv | 39 +++
 rtl/calc_disp_ser.sv | 55 +++++
 rtl/calc_param.sv | 248 ++++++++++++++++++++++++
 tb/tb_calc_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: command codes, operator,
// status and FSM state encodings, plus a power-of-ten helper for limit constants.
package calc_pkg;

   localparam logic [3:0] CMD_ADD  = 4'd10;
   localparam logic [3:0] CMD_SUB  = 4'd11;
   localparam logic [3:0] CMD_MUL  = 4'd12;
   localparam logic [3:0] CMD_DIV  = 4'd13;
   localparam logic [3:0] CMD_EQ   = 4'd14;
   localparam logic [3:0] CMD_BKSP = 4'd15;

   typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   typedef enum logic [1:0] {
      STAT_ERROR = 2'b00,
      STAT_BUSY  = 2'b01,
      STAT_READY = 2'b10
   } status_t;

   typedef enum logic [2:0] {S_ENTER_A, S_ENTER_B, S_COMPUTE, S_REFRESH, S_ERROR} state_t;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   function automatic op_t cmd_to_op(input logic [3:0] c);
      case (c)
         CMD_ADD: return OP_ADD;
         CMD_SUB: return OP_SUB;
         CMD_MUL: return OP_MUL;
         CMD_DIV: return OP_DIV;
         default: return OP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/calc_disp_ser.sv
// Display serialiser: on load, emits NDIG decimal digits of value (LSD first),
// or 4'hE at every position when err is set, one per cycle; done marks the last.
module calc_disp_ser
   import calc_pkg::*;
#(
   parameter int NDIG = 8,
   parameter int W    = 27,
   parameter int PW   = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   input  logic [W-1:0]  value,
   input  logic          err,
   output logic [3:0]    data,
   output logic [PW-1:0] pos,
   output logic          data_valid,
   output logic          done
);

   localparam logic [PW-1:0] LAST = PW'(NDIG - 1);
   localparam logic [W-1:0]  TEN  = W'(10);

   logic [W-1:0] shreg;
   logic         err_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data       <= '0;
         pos        <= '0;
         data_valid <= 1'b0;
         shreg      <= '0;
         err_q      <= 1'b0;
      end else if (load) begin
         err_q      <= err;
         data       <= err ? 4'hE : 4'(value % TEN);
         pos        <= '0;
         data_valid <= 1'b1;
         shreg      <= value / TEN;
      end else if (data_valid) begin
         if (pos == LAST) begin
            data_valid <= 1'b0;
            pos        <= '0;
            data       <= '0;
         end else begin
            pos   <= pos + PW'(1);
            data  <= err_q ? 4'hE : 4'(shreg % TEN);
            shreg <= shreg / TEN;
         end
      end
   end

   assign done = data_valid && (pos == LAST);

endmodule

// File: rtl/calc_param.sv
// Calculator core: keypad entry of operands A/B, one-cycle add/sub, W-cycle
// shift-add multiply and restoring divide, and a serialised display refresh.
module calc_param
   import calc_pkg::*;
#(
   parameter int NDIG = 8,
   parameter int W    = 27,
   parameter int PW   = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [3:0]    cmd,
   input  logic          cmd_valid,
   output logic [1:0]    status,
   output logic [3:0]    data,
   output logic [PW-1:0] pos,
   output logic          data_valid,
   output logic          neg
);

   localparam logic [W-1:0] MAX = W'(pow10(NDIG) - 64'd1);
   localparam logic [W-1:0] LIM = W'(pow10(NDIG - 1));
   localparam logic [W-1:0] TEN = W'(10);
   localparam int           CW  = $clog2(W + 1);

   state_t          state, state_n, ret_state, show_ret;
   op_t             op, op_n;
   logic [W-1:0]    a, a_n, b, b_n, disp_val, show_val;
   logic            neg_n, fresh, fresh_n, b_typed, btyped_n, err_flag, load_q;
   logic            show, show_err, done;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2*W-1:0]  acc, acc_n, mcand, mcand_n, mul_acc;
   logic [W-1:0]    mplier, mplier_n, rem, rem_n, quo, quo_n, div_q;
   logic [W-1:0]    cur, base, bksp_val;
   logic [W+3:0]    app;
   logic [W:0]      sum, rem_sh;
   logic            div_ge, take, is_digit, is_op;

   assign cur      = (state == S_ENTER_A) ? a : b;
   // A fresh result is replaced, not extended, by the next digit
   assign base     = (state == S_ENTER_A && fresh) ? '0 : cur;
   assign app      = ({4'b0000, base} << 3) + ({4'b0000, base} << 1) + {{W{1'b0}}, cmd};
   assign bksp_val = cur / TEN;
   assign sum      = {1'b0, a} + {1'b0, b};
   assign rem_sh   = {rem, quo[W-1]};
   assign div_ge   = rem_sh >= {1'b0, b};
   assign div_q    = {quo[W-2:0], div_ge};
   assign mul_acc  = mplier[0] ? acc + mcand : acc;
   assign take     = cmd_valid && (state == S_ENTER_A || state == S_ENTER_B);
   assign is_digit = cmd <= 4'd9;
   assign is_op    = (cmd >= CMD_ADD) && (cmd <= CMD_DIV);

   assign status = (state == S_ENTER_A || state == S_ENTER_B) ? STAT_READY :
                   (state == S_ERROR) ? STAT_ERROR : STAT_BUSY;

   always_comb begin
      state_n  = state;
      a_n      = a;
      b_n      = b;
      op_n     = op;
      neg_n    = neg;
      fresh_n  = fresh;
      btyped_n = b_typed;
      cnt_n    = cnt;
      acc_n    = acc;
      mcand_n  = mcand;
      mplier_n = mplier;
      rem_n    = rem;
      quo_n    = quo;
      show     = 1'b0;
      show_val = '0;
      show_ret = S_ENTER_A;
      show_err = 1'b0;
      case (state)
         S_ENTER_A: if (take) begin
            if (is_digit) begin
               if (base < LIM) begin
                  a_n      = W'(app);
                  fresh_n  = 1'b0;
                  neg_n    = 1'b0;
                  show     = 1'b1;
                  show_val = W'(app);
               end
            end else if (cmd == CMD_BKSP) begin
               a_n      = bksp_val;
               show     = 1'b1;
               show_val = bksp_val;
            end else if (is_op) begin
               op_n     = cmd_to_op(cmd);
               b_n      = '0;
               neg_n    = 1'b0;
               fresh_n  = 1'b0;
               btyped_n = 1'b0;
               show     = 1'b1;
               show_ret = S_ENTER_B;
            end
         end
         S_ENTER_B: if (take) begin
            if (is_digit) begin
               if (base < LIM) begin
                  b_n      = W'(app);
                  btyped_n = 1'b1;
                  show     = 1'b1;
                  show_val = W'(app);
                  show_ret = S_ENTER_B;
               end
            end else if (cmd == CMD_BKSP) begin
               b_n      = bksp_val;
               btyped_n = 1'b1;
               show     = 1'b1;
               show_val = bksp_val;
               show_ret = S_ENTER_B;
            end else if (is_op) begin
               if (!b_typed) op_n = cmd_to_op(cmd);
            end else begin
               case (op)
                  OP_SUB: begin
                     fresh_n = 1'b1;
                     show    = 1'b1;
                     if (a < b) begin
                        a_n      = b - a;
                        neg_n    = 1'b1;
                        show_val = b - a;
                     end else begin
                        a_n      = a - b;
                        neg_n    = 1'b0;
                        show_val = a - b;
                     end
                  end
                  OP_MUL: begin
                     cnt_n    = '0;
                     acc_n    = '0;
                     mcand_n  = {{W{1'b0}}, a};
                     mplier_n = b;
                     state_n  = S_COMPUTE;
                  end
                  OP_DIV: begin
                     cnt_n   = '0;
                     rem_n   = '0;
                     quo_n   = a;
                     state_n = S_COMPUTE;
                  end
                  default: begin
                     show = 1'b1;
                     if (sum > {1'b0, MAX}) begin
                        show_err = 1'b1;
                        show_ret = S_ERROR;
                     end else begin
                        a_n      = W'(sum);
                        fresh_n  = 1'b1;
                        neg_n    = 1'b0;
                        show_val = W'(sum);
                     end
                  end
               endcase
            end
         end
         S_COMPUTE: begin
            cnt_n = cnt + CW'(1);
            if (op == OP_MUL) begin
               acc_n    = mul_acc;
               mcand_n  = mcand << 1;
               mplier_n = mplier >> 1;
            end else begin
               rem_n = div_ge ? rem_sh[W-1:0] - b : rem_sh[W-1:0];
               quo_n = div_q;
            end
            // Final iteration: commit the result or flag overflow / divide by zero
            if (cnt == CW'(W - 1)) begin
               show    = 1'b1;
               fresh_n = 1'b1;
               if ((op == OP_MUL && mul_acc > {{W{1'b0}}, MAX}) || (op != OP_MUL && b == '0)) begin
                  show_err = 1'b1;
                  show_ret = S_ERROR;
               end else if (op == OP_MUL) begin
                  a_n      = W'(mul_acc);
                  show_val = W'(mul_acc);
               end else begin
                  a_n      = div_q;
                  show_val = div_q;
               end
            end
         end
         S_REFRESH: if (done) state_n = ret_state;
         S_ERROR:   ;
         default:   state_n = S_ENTER_A;
      endcase
      if (show) state_n = S_REFRESH;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_ENTER_A;
      else       state <= state_n;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a         <= '0;
         b         <= '0;
         op        <= OP_NONE;
         neg       <= 1'b0;
         fresh     <= 1'b0;
         b_typed   <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         rem       <= '0;
         quo       <= '0;
         disp_val  <= '0;
         err_flag  <= 1'b0;
         ret_state <= S_ENTER_A;
         load_q    <= 1'b0;
      end else begin
         a       <= a_n;
         b       <= b_n;
         op      <= op_n;
         neg     <= neg_n;
         fresh   <= fresh_n;
         b_typed <= btyped_n;
         cnt     <= cnt_n;
         acc     <= acc_n;
         mcand   <= mcand_n;
         mplier  <= mplier_n;
         rem     <= rem_n;
         quo     <= quo_n;
         load_q  <= show;
         if (show) begin
            disp_val  <= show_val;
            err_flag  <= show_err;
            ret_state <= show_ret;
         end
      end
   end

   calc_disp_ser #(.NDIG(NDIG), .W(W), .PW(PW)) u_disp (
      .clock      (clock),
      .reset      (reset),
      .load       (load_q),
      .value      (disp_val),
      .err        (err_flag),
      .data       (data),
      .pos        (pos),
      .data_valid (data_valid),
      .done       (done)
   );

endmodule

// File: tb/tb_calc_param.sv
// Directed bench for calc_param: key sequences drive the core, expected display
// digits are queued per refresh and matched against every data_valid beat.
module tb_calc_param;

   localparam int NDIG = 8;
   localparam int W    = 27;
   localparam int PW   = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    cmd = 4'd0;
   logic          cmd_valid = 1'b0;
   logic [1:0]    status;
   logic [3:0]    data;
   logic [PW-1:0] pos;
   logic          data_valid;
   logic          neg;

   int checks = 0;
   int errors = 0;
   int last_first = 0;
   int last_busy = 0;
   logic [PW+3:0] exp_q[$];

   always #5 clock = ~clock;

   calc_param #(.NDIG(NDIG), .W(W), .PW(PW)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .status     (status),
      .data       (data),
      .pos        (pos),
      .data_valid (data_valid),
      .neg        (neg)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_val(input longint unsigned v, input logic err);
      longint unsigned vv;
      logic [3:0] d;
      vv = v;
      for (int i = 0; i < NDIG; i++) begin
         d = err ? 4'hE : 4'(vv % 10);
         exp_q.push_back({PW'(i), d});
         vv = vv / 10;
      end
   endtask

   // Scoreboard: every displayed digit must match the head of the queue
   always @(negedge clock) begin
      if (!reset && data_valid) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL spurious_digit: got pos %0d data %0h expected no output", pos, data);
         end
         if (exp_q.size() != 0) chk("digit", {24'd0, pos, data}, {24'd0, exp_q.pop_front()});
      end
   end

   task automatic press(input logic [3:0] k);
      @(negedge clock);
      cmd = k;
      cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 1;
      last_first = 0;
      last_busy = 0;
      while (status == 2'b01 && n < 400) begin
         if (data_valid && last_first == 0) last_first = n;
         last_busy++;
         @(negedge clock);
         n++;
      end
      chk("idle_within_budget", 32'(n < 400), 1);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
   endtask

   task automatic key(input logic [3:0] k, input longint unsigned v, input logic err);
      expect_val(v, err);
      press(k);
      wait_idle();
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_status", 32'(status), 2);
      chk("rst_data_valid", 32'(data_valid), 0);
      chk("rst_pos", 32'(pos), 0);
      chk("rst_data", 32'(data), 0);
      chk("rst_neg", 32'(neg), 0);
      reset = 1'b0;

      key(4'd1, 1, 1'b0);
      chk("digit_first_dv_cycle", 32'(last_first), 2);
      chk("digit_busy_cycles", 32'(last_busy), NDIG + 1);
      key(4'd2, 12, 1'b0);
      key(4'd10, 0, 1'b0);
      key(4'd3, 3, 1'b0);
      key(4'd4, 34, 1'b0);
      key(4'd14, 46, 1'b0);
      chk("add_busy_cycles", 32'(last_busy), NDIG + 1);
      chk("add_neg", 32'(neg), 0);
      chk("add_status", 32'(status), 2);

      key(4'd5, 5, 1'b0);
      key(4'd11, 0, 1'b0);
      key(4'd9, 9, 1'b0);
      key(4'd14, 4, 1'b0);
      chk("sub_neg", 32'(neg), 1);
      key(4'd7, 7, 1'b0);

      key(4'd15, 0, 1'b0);
      key(4'd1, 1, 1'b0);
      key(4'd2, 12, 1'b0);
      key(4'd12, 0, 1'b0);
      key(4'd3, 3, 1'b0);
      key(4'd14, 36, 1'b0);
      chk("mul_busy_cycles", 32'(last_busy), W + NDIG + 1);
      chk("mul_first_dv_cycle", 32'(last_first), W + 2);

      // A key pressed while the display refreshes must be dropped
      expect_val(5, 1'b0);
      press(4'd5);
      repeat (3) @(negedge clock);
      cmd = 4'd9;
      cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      wait_idle();
      key(4'd0, 50, 1'b0);

      do_reset();
      for (int i = 1; i <= NDIG; i++) key(4'd9, (64'd10 ** i) - 1, 1'b0);
      press(4'd9);
      wait_idle();
      chk("ninth_digit_dropped", 32'(last_busy), 0);
      key(4'd15, 9999999, 1'b0);
      key(4'd9, 99999999, 1'b0);
      key(4'd10, 0, 1'b0);
      key(4'd1, 1, 1'b0);
      key(4'd14, 0, 1'b1);
      chk("add_overflow_status", 32'(status), 0);

      do_reset();
      key(4'd9, 9, 1'b0);
      key(4'd13, 0, 1'b0);
      key(4'd2, 2, 1'b0);
      key(4'd14, 4, 1'b0);
      chk("div_busy_cycles", 32'(last_busy), W + NDIG + 1);
      key(4'd8, 8, 1'b0);
      key(4'd13, 0, 1'b0);
      key(4'd0, 0, 1'b0);
      key(4'd14, 0, 1'b1);
      chk("div0_status", 32'(status), 0);
      press(4'd5);
      wait_idle();
      chk("error_ignores_cmd", 32'(last_busy), 0);
      chk("error_status_held", 32'(status), 0);

      do_reset();
      key(4'd1, 1, 1'b0);
      key(4'd2, 12, 1'b0);
      key(4'd12, 0, 1'b0);
      key(4'd3, 3, 1'b0);
      press(4'd14);
      repeat (5) @(negedge clock);
      chk("mid_mul_busy", 32'(status), 1);
      #2 reset = 1'b1;
      #1;
      chk("abort_status", 32'(status), 2);
      chk("abort_pos", 32'(pos), 0);
      chk("abort_data_valid", 32'(data_valid), 0);
      @(negedge clock);
      reset = 1'b0;
      key(4'd2, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
